// File: rtl/wb_buffer_if.sv
// rtl/wb_buffer_if.sv - producer, regfile-write and forwarding signals of the writeback buffer
interface wb_buffer_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 3
);
    logic              ready;

    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_accept;

    logic              alu_valid;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;
    logic              alu_accept;

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    logic [ADDR_W-1:0] fwd_addr1;
    logic [ADDR_W-1:0] fwd_addr2;
    logic              fwd_hit1;
    logic              fwd_hit2;
    logic [DATA_W-1:0] fwd_data1;
    logic [DATA_W-1:0] fwd_data2;

    logic [CNT_W-1:0]  count;
    logic              full;

    modport slave (
        input  ready,
        input  ld_valid, ld_addr, ld_data,
        output ld_accept,
        input  alu_valid, alu_addr, alu_data,
        output alu_accept,
        output we, waddr, wdata,
        input  fwd_addr1, fwd_addr2,
        output fwd_hit1, fwd_hit2, fwd_data1, fwd_data2,
        output count, full
    );

    modport master (
        output ready,
        output ld_valid, ld_addr, ld_data,
        input  ld_accept,
        output alu_valid, alu_addr, alu_data,
        input  alu_accept,
        input  we, waddr, wdata,
        output fwd_addr1, fwd_addr2,
        input  fwd_hit1, fwd_hit2, fwd_data1, fwd_data2,
        input  count, full
    );
endinterface

// File: rtl/wb_buffer.sv
// rtl/wb_buffer.sv - in-order writeback FIFO between MEM and the regfile port, with forwarding lookup
module wb_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int PTR_W  = $clog2(DEPTH),
    parameter int CNT_W  = PTR_W + 1
) (
    input  logic        clk,
    input  logic        rst,
    wb_buffer_if.slave  bus
);
    logic [ADDR_W-1:0] mem_addr_q [DEPTH];
    logic [DATA_W-1:0] mem_data_q [DEPTH];

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              pop;
    logic [CNT_W:0]    free;
    logic [CNT_W:0]    alu_need;
    logic              ld_needs;
    logic              alu_needs;
    logic              ld_acc;
    logic              alu_acc;
    logic              ld_push;
    logic              alu_push;
    logic [PTR_W-1:0]  alu_slot;

    logic              hit1, hit2;
    logic [DATA_W-1:0] data1, data2;

    // Outputs are forced low while rst is held so nothing leaks during reset.
    always_comb begin
        pop      = !rst && bus.ready && (count_q != '0);
        free     = (CNT_W+1)'(DEPTH) - {1'b0, count_q} + {{CNT_W{1'b0}}, pop};
        ld_needs  = bus.ld_valid && (bus.ld_addr != '0);
        alu_needs = bus.alu_valid && (bus.alu_addr != '0);
        alu_need  = {{CNT_W{1'b0}}, 1'b1} + {{CNT_W{1'b0}}, ld_needs};

        ld_acc  = !rst && bus.ready && bus.ld_valid
                  && ((bus.ld_addr == '0) || (free >= (CNT_W+1)'(1)));
        alu_acc = !rst && bus.ready && bus.alu_valid
                  && ((bus.alu_addr == '0) || (free >= alu_need));

        ld_push  = ld_acc && ld_needs;
        alu_push = alu_acc && alu_needs;
        alu_slot = tail_q + PTR_W'(ld_push);

        head_d  = head_q + PTR_W'(pop);
        tail_d  = tail_q + PTR_W'(ld_push) + PTR_W'(alu_push);
        count_d = count_q + CNT_W'(ld_push) + CNT_W'(alu_push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage carries no reset; occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (ld_push) begin
            mem_addr_q[tail_q] <= bus.ld_addr;
            mem_data_q[tail_q] <= bus.ld_data;
        end
        if (alu_push) begin
            mem_addr_q[alu_slot] <= bus.alu_addr;
            mem_data_q[alu_slot] <= bus.alu_data;
        end
    end

    // Walk from oldest to youngest so the last match seen is the newest one.
    always_comb begin
        hit1  = 1'b0;
        hit2  = 1'b0;
        data1 = '0;
        data2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!rst && (CNT_W'(i) < count_q)) begin
                if ((bus.fwd_addr1 != '0) && (mem_addr_q[head_q + PTR_W'(i)] == bus.fwd_addr1)) begin
                    hit1  = 1'b1;
                    data1 = mem_data_q[head_q + PTR_W'(i)];
                end
                if ((bus.fwd_addr2 != '0) && (mem_addr_q[head_q + PTR_W'(i)] == bus.fwd_addr2)) begin
                    hit2  = 1'b1;
                    data2 = mem_data_q[head_q + PTR_W'(i)];
                end
            end
        end
    end

    assign bus.ld_accept  = ld_acc;
    assign bus.alu_accept = alu_acc;
    assign bus.we         = pop;
    assign bus.waddr      = pop ? mem_addr_q[head_q] : '0;
    assign bus.wdata      = pop ? mem_data_q[head_q] : '0;
    assign bus.fwd_hit1   = hit1;
    assign bus.fwd_hit2   = hit2;
    assign bus.fwd_data1  = data1;
    assign bus.fwd_data2  = data2;
    assign bus.count      = rst ? '0 : count_q;
    assign bus.full       = !rst && (count_q == CNT_W'(DEPTH));
endmodule
